// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the UART program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int unsigned DEF_ADDR_W     = 14;
  localparam int unsigned DEF_TIMEOUT    = 1000000;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Assembles four received bytes into a little-endian 32-bit word.
module byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  lane_q;
  logic [31:0] word_q;

  // Asserted in the cycle the last lane of a word is being accepted.
  assign word_done = byte_valid && (lane_q == 2'(BYTES_PER_WORD - 1));
  assign word      = word_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane_q <= '0;
      word_q <= '0;
    end else if (byte_valid) begin
      word_q[lane_q*8 +: 8] <= byte_data;
      lane_q                <= lane_q + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed program over a byte stream and writes it into
// instruction memory, holding the CPU in reset while the load is in progress.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic              start_load;
  logic              active;
  logic              accept;
  logic              pack_valid;
  logic              word_done;
  logic              timeout_hit;
  logic              final_wr;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_n;
  logic [15:0]       n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       to_q;
  logic              wr_pend_q;
  logic [31:0]       packed_word;

  assign active      = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);
  assign rx_ready    = active && !wr_pend_q;
  assign accept      = rx_valid && rx_ready;
  assign pack_valid  = accept && (state_q == DATA);
  assign len_n       = {rx_data, len_lo_q};
  assign timeout_hit = !accept && (to_q == TIMEOUT - 1);
  assign final_wr    = wr_pend_q && (32'(addr_q) == 32'(n_q) - 32'd1);

  assign imem_we    = wr_pend_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = packed_word;
  assign cpu_hold   = active;
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_load),
    .byte_valid (pack_valid),
    .byte_data  (rx_data),
    .word       (packed_word),
    .word_done  (word_done)
  );

  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN0;
          start_load = 1'b1;
        end
      end
      LEN0: begin
        if (accept)           state_d = LEN1;
        else if (timeout_hit) state_d = ERR;
      end
      LEN1: begin
        if (accept) begin
          if (len_n == 16'd0)                  state_d = DONE;
          else if ({17'b0, len_n} > MAX_WORDS) state_d = ERR;
          else                                 state_d = DATA;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      DATA: begin
        // Completion of the final write takes priority over a coincident timeout.
        if (final_wr)         state_d = DONE;
        else if (timeout_hit) state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_lo_q  <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      to_q      <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_load) begin
        addr_q    <= '0;
        to_q      <= '0;
        wr_pend_q <= 1'b0;
      end else if (active) begin
        to_q      <= accept ? '0 : to_q + 32'd1;
        wr_pend_q <= word_done;
        if (state_q == LEN0 && accept) len_lo_q <= rx_data;
        if (state_q == LEN1 && accept) n_q      <= len_n;
        if (wr_pend_q)                 addr_q   <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a byte-count based model.
module tb_program_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned TMO   = 100;
  localparam int unsigned DEPTH = 16;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int total = 0;
  int bad = 0;
  int dut_we_cnt = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] img [DEPTH];

  // Reference model: progress is tracked purely by bytes received and words written.
  bit          m_active = 0, m_done = 0, m_err = 0, m_pend = 0;
  int          m_nrecv = 0, m_nwords = 0, m_idle = 0, m_written = 0, m_pend_addr = 0;
  logic [7:0]  m_lo = '0;
  logic [31:0] m_cur = '0, m_pend_data = '0;

  program_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  initial begin
    int k;
    forever begin
      @(negedge clk);
      chk("rx_ready", 32'(rx_ready), 32'(m_active && !m_pend));
      chk("imem_we",  32'(imem_we),  32'(m_pend));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_active));
      chk("done",     32'(done),     32'(m_done));
      chk("err",      32'(err),      32'(m_err));
      if (m_pend) begin
        chk("imem_addr",  32'(imem_addr), 32'(m_pend_addr));
        chk("imem_wdata", imem_wdata,     m_pend_data);
      end
      if (imem_we) begin
        mem[imem_addr] = imem_wdata;
        dut_we_cnt++;
      end
      if (rst) begin
        m_active = 0; m_done = 0; m_err = 0; m_pend = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_done = 0; m_err = 0;
          m_nrecv = 0; m_idle = 0; m_written = 0;
          for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        end
      end else if (m_pend) begin
        m_pend = 0;
        m_written++;
        if (m_written == m_nwords) begin
          m_active = 0; m_done = 1;
        end else begin
          m_idle++;
          if (m_idle == TMO) begin m_active = 0; m_err = 1; end
        end
      end else if (rx_valid) begin
        m_idle = 0;
        m_nrecv++;
        if (m_nrecv == 1) begin
          m_lo = rx_data;
        end else if (m_nrecv == 2) begin
          m_nwords = int'({rx_data, m_lo});
          if (m_nwords == 0) begin
            m_active = 0; m_done = 1;
          end else if (m_nwords > (1 << AW)) begin
            m_active = 0; m_err = 1;
          end
        end else begin
          k = m_nrecv - 3;
          m_cur[8*(k%4) +: 8] = rx_data;
          if (k % 4 == 3) begin
            m_pend = 1; m_pend_addr = k / 4; m_pend_data = m_cur;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_active = 0; m_err = 1; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_q(input byte_q_t bq, input bit b2b, input bit noise);
    bit acc;
    int budget;
    foreach (bq[i]) begin
      if (!b2b) begin
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      rx_valid = 1'b1;
      rx_data  = bq[i];
      if (noise && i == 3) start = 1'b1;
      acc = 0;
      budget = 0;
      while (!acc && budget < 50) begin
        @(negedge clk);
        acc = rx_valid && rx_ready;
        @(posedge clk);
        #1;
        budget++;
      end
      start = 1'b0;
      chk("rx_accept", 32'(acc), 32'd1);
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    int n = 0;
    while (!(done || err) && n < bound) begin
      tick();
      n++;
    end
    chk("end_reached", 32'(done || err), 32'd1);
  endtask

  task automatic check_outputs_zero();
    chk("rst_rx_ready",   32'(rx_ready),   32'd0);
    chk("rst_imem_we",    32'(imem_we),    32'd0);
    chk("rst_imem_addr",  32'(imem_addr),  32'd0);
    chk("rst_imem_wdata", imem_wdata,      32'd0);
    chk("rst_cpu_hold",   32'(cpu_hold),   32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_err",        32'(err),        32'd0);
  endtask

  task automatic do_load(input logic [15:0] nfield, input int nw, input bit b2b, input bit noise);
    byte_q_t bq;
    bq.push_back(nfield[7:0]);
    bq.push_back(nfield[15:8]);
    for (int w = 0; w < nw; w++) begin
      img[w] = $urandom;
      for (int b = 0; b < 4; b++) bq.push_back(img[w][8*b +: 8]);
    end
    pulse_start();
    send_q(bq, b2b, noise);
    wait_end(300);
  endtask

  task automatic check_image(input int nw);
    for (int w = 0; w < nw; w++) chk("mem_image", mem[w], img[w]);
  endtask

  initial begin
    byte_q_t bq;
    int we0;
    int nw;

    repeat (3) tick();
    check_outputs_zero();
    rst = 1'b0;
    tick();

    // Two-word reference program
    bq = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    we0 = dut_we_cnt;
    pulse_start();
    send_q(bq, 1'b1, 1'b0);
    wait_end(50);
    chk("ref_mem0", mem[0], 32'h00A00513);
    chk("ref_mem1", mem[1], 32'h00100593);
    chk("ref_done", 32'(done), 32'd1);
    chk("ref_hold", 32'(cpu_hold), 32'd0);
    chk("ref_writes", 32'(dut_we_cnt - we0), 32'd2);

    // Bytes offered while DONE must not be consumed
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (3) tick();
    chk("done_no_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;

    // Zero-length program
    bq = '{8'h00, 8'h00};
    we0 = dut_we_cnt;
    pulse_start();
    send_q(bq, 1'b0, 1'b0);
    wait_end(20);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_writes", 32'(dut_we_cnt - we0), 32'd0);

    // Stream stalls mid-word
    bq = '{8'h01, 8'h00, 8'h11, 8'h22};
    we0 = dut_we_cnt;
    pulse_start();
    send_q(bq, 1'b1, 1'b0);
    wait_end(TMO + 20);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_hold", 32'(cpu_hold), 32'd0);
    chk("tmo_writes", 32'(dut_we_cnt - we0), 32'd0);

    // Reset in the middle of a three-word load, then a clean load
    bq = '{8'h03, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    pulse_start();
    send_q(bq, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_outputs_zero();
    rst = 1'b0;
    tick();
    do_load(16'd3, 3, 1'b0, 1'b0);
    chk("after_rst_done", 32'(done), 32'd1);
    check_image(3);

    // Word count one beyond capacity
    bq = '{8'h11, 8'h00};
    we0 = dut_we_cnt;
    pulse_start();
    send_q(bq, 1'b1, 1'b0);
    wait_end(5);
    chk("oversize_err", 32'(err), 32'd1);
    chk("oversize_writes", 32'(dut_we_cnt - we0), 32'd0);

    // Exactly full memory
    do_load(16'd16, 16, 1'b1, 1'b0);
    chk("full_done", 32'(done), 32'd1);
    check_image(16);

    // Randomized loads, back-to-back or gapped, with stray start pulses
    for (int t = 0; t < 12; t++) begin
      nw = int'($urandom_range(1, 16));
      do_load(16'(nw), nw, (t < 4) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("rand_done", 32'(done), 32'd1);
      check_image(nw);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 14, instruction-memory word-address width.
REQ-002 Parameter TIMEOUT, default 1000000, maximum number of idle clk cycles allowed between received bytes during a load.
REQ-003 clk  input  1  the single clock; all logic updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  single-cycle pulse that requests a new program load.
REQ-006 rx_valid  input  1  rx_data holds a byte.
REQ-007 rx_data  input  8  byte from the UART receiver.
REQ-008 rx_ready  output  1  loader accepts a byte; a byte transfers when rx_valid && rx_ready.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  ADDR_W  word address for the write.
REQ-011 imem_wdata  output  32  instruction word for the write.
REQ-012 cpu_hold  output  1  holds the CPU core in reset while a load is active.
REQ-013 done  output  1  level; the last load completed successfully.
REQ-014 err  output  1  level; the last load aborted.

Function
REQ-015 States: IDLE, LEN0, LEN1, DATA, DONE, ERR.
REQ-016 IDLE: rx_ready=0 and cpu_hold=0; start moves to LEN0, clears done and err, and zeroes the address, byte-lane and timeout counters.
REQ-017 LEN0/LEN1: accept one byte each, forming the 16-bit word count N, little-endian (LEN0 = low byte).
REQ-018 After LEN1: if N=0, go to DONE; if N > 2^ADDR_W, go to ERR; otherwise go to DATA.
REQ-019 DATA: packs bytes little-endian (first byte -> wdata[7:0]); when the 4th byte of a word is accepted, the next cycle asserts imem_we for exactly one cycle with imem_addr equal to the word index (starting at 0).
REQ-020 Address counter increments after each write; after write N-1 the FSM goes to DONE in the same cycle as the final imem_we.
REQ-021 rx_ready=1 in LEN0, LEN1 and DATA, except during the imem_we cycle (rx_ready=0 there); latency from byte 4 to write is exactly 1 cycle.
REQ-022 cpu_hold=1 in LEN0, LEN1 and DATA, and during the imem_we cycle of the final word.
REQ-023 Timeout counter resets on every accepted byte and increments otherwise in LEN0, LEN1 and DATA; reaching TIMEOUT goes to ERR.
REQ-024 DONE: done=1, cpu_hold=0; ERR: err=1, cpu_hold=0; both stay until start returns the FSM to LEN0.
REQ-025 start is ignored in LEN0, LEN1 and DATA.
REQ-026 rx bytes presented in IDLE, DONE or ERR are not consumed (rx_ready=0).
REQ-027 imem_we never asserts outside DATA; a partial word (fewer than 4 bytes) is never written.

Reset
REQ-028 rst returns the FSM to IDLE from any state, including mid-DATA, within the same edge.
REQ-029 rst drives all outputs to 0: rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err.
REQ-030 rst zeroes all internal counters and the byte-assembly register.

Structure
REQ-031 State encodings and the default ADDR_W/TIMEOUT values are placed in the shared parameters include file.
REQ-032 A single sub-module, byte_packer, holds the 4-byte little-endian assembly register and lane counter; the FSM and counters reside in program_loader.

Verification
REQ-033 start, bytes 02 00, 13 05 A0 00, 93 05 10 00 -> imem_we twice: addr 0 wdata 0x00A00513, addr 1 wdata 0x00100593; then done=1, cpu_hold=0.
REQ-034 start, bytes 00 00 -> DONE immediately after LEN1; no imem_we; done=1.
REQ-035 start, bytes 01 00, 11 22, then silence for TIMEOUT cycles (use TIMEOUT=100 in the bench) -> err=1, no imem_we, cpu_hold=0.
REQ-036 rst asserted after 6 DATA bytes of a 3-word load -> next cycle all outputs are 0 and the state is IDLE; a subsequent full load writes from addr 0.
REQ-037 Bench with ADDR_W=4, count 0x0011 -> err=1 after LEN1; no imem_we.
REQ-038 rx_valid held high continuously with back-to-back bytes -> rx_ready=0 on each imem_we cycle; no byte is lost or duplicated (compare memory against the golden image).
